dpu_pio_responder: RTL and testbench

//  Target (responder) end of the DPU PIO byte-command bus. Accepts one host command per valid/ready handshake,

---
 rtl/dpu_pio_pkg.sv | 51 +++++
 rtl/dpu_pio_addr_decode.sv | 44 ++++
 rtl/dpu_pio_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_dpu_pio_responder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpu_pio_pkg.sv
// Shared types and address-map helpers for the DPU PIO responder.
package dpu_pio_pkg;

  // Default geometry of the DPU buffers behind the PIO bus.
  localparam int unsigned NUM_LAYERS_DEF = 18;
  localparam int unsigned MAX_CH_DEF     = 256;
  localparam int unsigned MAX_FMAP_DEF   = 65536;
  localparam int unsigned MAX_WBUF_DEF   = 147456;

  // Host command opcodes carried on cmd_type.
  typedef enum logic [2:0] {
    CMD_WR        = 3'd0,
    CMD_RUN       = 3'd1,
    CMD_RD        = 3'd2,
    CMD_SET_LAYER = 3'd3,
    CMD_RUN_ALL   = 3'd4,
    CMD_SCALE     = 3'd5,
    CMD_DESC      = 3'd6,
    CMD_RSVD      = 3'd7
  } pio_cmd_e;

  // Responder handshake FSM.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RSP     = 2'd3
  } pio_state_e;

  // Write-address region in the flat byte map: weights, then bias, then fmap.
  typedef enum logic [1:0] {
    REG_WBUF = 2'd0,
    REG_BIAS = 2'd1,
    REG_FMAP = 2'd2,
    REG_NONE = 2'd3
  } pio_region_e;

  // First byte of the input-fmap window (bias region is 4 bytes per channel).
  function automatic int unsigned fmap_base(input int unsigned max_wbuf,
                                            input int unsigned max_ch);
    return max_wbuf + max_ch * 4;
  endfunction

  // One past the last writable byte of the map.
  function automatic int unsigned fmap_limit(input int unsigned max_wbuf,
                                             input int unsigned max_ch,
                                             input int unsigned max_fmap);
    return fmap_base(max_wbuf, max_ch) + max_fmap;
  endfunction

endpackage

// File: rtl/dpu_pio_addr_decode.sv
// Combinational decode of a 24-bit PIO byte address into a buffer region
// and the offset within that region.
module dpu_pio_addr_decode
  import dpu_pio_pkg::*;
#(
  parameter int unsigned MAX_CH   = MAX_CH_DEF,
  parameter int unsigned MAX_FMAP = MAX_FMAP_DEF,
  parameter int unsigned MAX_WBUF = MAX_WBUF_DEF
) (
  input  logic [23:0] addr,
  output pio_region_e wr_region,
  output logic        rd_in_range,
  output logic [17:0] wbuf_off,
  output logic [9:0]  bias_off,
  output logic [15:0] fmap_off
);

  localparam logic [23:0] WBUF_END = 24'(MAX_WBUF);
  localparam logic [23:0] BIAS_END = 24'(fmap_base(MAX_WBUF, MAX_CH));
  localparam logic [23:0] FMAP_END = 24'(fmap_limit(MAX_WBUF, MAX_CH, MAX_FMAP));
  localparam logic [23:0] RD_END   = 24'(MAX_FMAP);

  // Region boundaries are compared as unsigned 24-bit quantities.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    wr_region = REG_NONE;
    if (addr < WBUF_END) begin
      wr_region = REG_WBUF;
    end else if (addr < BIAS_END) begin
      wr_region = REG_BIAS;
    end else if (addr < FMAP_END) begin
      wr_region = REG_FMAP;
    end
  end

  assign rd_in_range = (addr < RD_END);

  // Offsets only need the low bits: subtraction modulo the port width gives
  // the same result as a full-width subtract followed by truncation.
  assign wbuf_off = addr[17:0];
  assign bias_off = addr[9:0]  - WBUF_END[9:0];
  assign fmap_off = addr[15:0] - BIAS_END[15:0];

endmodule

// File: rtl/dpu_pio_responder.sv
// Target end of the DPU PIO byte-command bus: accepts one host command per
// handshake, turns it into buffer write strobes, register updates, run pulses
// or an fmap read, and returns read bytes on rsp_valid/rsp_data.
module dpu_pio_responder
  import dpu_pio_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int unsigned MAX_CH     = MAX_CH_DEF,
  parameter int unsigned MAX_FMAP   = MAX_FMAP_DEF,
  parameter int unsigned MAX_WBUF   = MAX_WBUF_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  // host command channel
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_type,
  input  logic [23:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  // read response
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  // core status
  input  logic        core_busy,
  input  logic        core_reload_req,
  // weight buffer write port
  output logic        wbuf_we,
  output logic [17:0] wbuf_addr,
  output logic [7:0]  wbuf_wdata,
  // bias buffer write port
  output logic        bias_we,
  output logic [9:0]  bias_addr,
  output logic [7:0]  bias_wdata,
  // input fmap write port
  output logic        fmap_we,
  output logic [15:0] fmap_waddr,
  output logic [7:0]  fmap_wdata,
  // output fmap read port (synchronous BRAM, data one cycle after fmap_re)
  output logic        fmap_re,
  output logic [15:0] fmap_raddr,
  input  logic [7:0]  fmap_rdata,
  // control registers and pulses
  output logic [4:0]  layer_sel,
  output logic        run_pulse,
  output logic        run_all_pulse,
  output logic [15:0] scale_out,
  output logic        desc_we,
  output logic [4:0]  desc_layer,
  output logic [3:0]  desc_field,
  output logic [7:0]  desc_wdata,
  output logic        err_pulse
);

  localparam logic [4:0] LAYER_END = 5'(NUM_LAYERS);

  pio_state_e  state_q, state_d;
  pio_cmd_e    cmd;
  pio_region_e wr_region;
  logic        rd_in_range;
  logic [17:0] wbuf_off;
  logic [9:0]  bias_off;
  logic [15:0] fmap_off;
  logic        accept;
  logic        rd_pend_q;
  logic        rd_err_q;

  assign cmd = pio_cmd_e'(cmd_type);

  dpu_pio_addr_decode #(
    .MAX_CH   (MAX_CH),
    .MAX_FMAP (MAX_FMAP),
    .MAX_WBUF (MAX_WBUF)
  ) u_addr_decode (
    .addr        (cmd_addr),
    .wr_region   (wr_region),
    .rd_in_range (rd_in_range),
    .wbuf_off    (wbuf_off),
    .bias_off    (bias_off),
    .fmap_off    (fmap_off)
  );

  // State register; an in-flight read is abandoned on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and accept decision. Commands are only taken in IDLE, and only
  // while the core is idle or parked waiting for a weight reload.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && (!core_busy || core_reload_req)) begin
          accept  = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK:     state_d = rd_pend_q ? ST_RD_WAIT : ST_IDLE;
      ST_RD_WAIT: state_d = ST_RSP;
      ST_RSP:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Command execution: strobes and pulses are live for the single ACK cycle
  // following the accept edge; register-type results persist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready     <= 1'b0;
      wbuf_we       <= 1'b0;
      wbuf_addr     <= '0;
      wbuf_wdata    <= '0;
      bias_we       <= 1'b0;
      bias_addr     <= '0;
      bias_wdata    <= '0;
      fmap_we       <= 1'b0;
      fmap_waddr    <= '0;
      fmap_wdata    <= '0;
      fmap_re       <= 1'b0;
      fmap_raddr    <= '0;
      layer_sel     <= '0;
      run_pulse     <= 1'b0;
      run_all_pulse <= 1'b0;
      scale_out     <= '0;
      desc_we       <= 1'b0;
      desc_layer    <= '0;
      desc_field    <= '0;
      desc_wdata    <= '0;
      err_pulse     <= 1'b0;
      rd_pend_q     <= 1'b0;
      rd_err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults followed by conditional overrides: the last <= in the block wins, giving clean one-cycle pulses.
      cmd_ready     <= 1'b0;
      wbuf_we       <= 1'b0;
      bias_we       <= 1'b0;
      fmap_we       <= 1'b0;
      fmap_re       <= 1'b0;
      run_pulse     <= 1'b0;
      run_all_pulse <= 1'b0;
      desc_we       <= 1'b0;
      err_pulse     <= 1'b0;
      if (accept) begin
        cmd_ready <= 1'b1;
        rd_pend_q <= (cmd == CMD_RD);
        rd_err_q  <= 1'b0;
        case (cmd)
          CMD_WR: begin
            case (wr_region)
              REG_WBUF: begin
                wbuf_we    <= 1'b1;
                wbuf_addr  <= wbuf_off;
                wbuf_wdata <= cmd_data;
              end
              REG_BIAS: begin
                bias_we    <= 1'b1;
                bias_addr  <= bias_off;
                bias_wdata <= cmd_data;
              end
              REG_FMAP: begin
                fmap_we    <= 1'b1;
                fmap_waddr <= fmap_off;
                fmap_wdata <= cmd_data;
              end
              default: err_pulse <= 1'b1;
            endcase
          end
          CMD_RD: begin
            if (rd_in_range) begin
              fmap_re    <= 1'b1;
              fmap_raddr <= cmd_addr[15:0];
            end else begin
              // Out-of-range read still completes with a 0x00 response.
              err_pulse <= 1'b1;
              rd_err_q  <= 1'b1;
            end
          end
          CMD_SET_LAYER: layer_sel     <= cmd_data[4:0];
          CMD_RUN:       run_pulse     <= 1'b1;
          CMD_RUN_ALL:   run_all_pulse <= 1'b1;
          CMD_SCALE: begin
            if (cmd_addr[0]) begin
              scale_out[15:8] <= cmd_data;
            end else begin
              scale_out[7:0]  <= cmd_data;
            end
          end
          CMD_DESC: begin
            if (cmd_addr[8:4] < LAYER_END) begin
              desc_we    <= 1'b1;
              desc_layer <= cmd_addr[8:4];
              desc_field <= cmd_addr[3:0];
              desc_wdata <= cmd_data;
            end else begin
              err_pulse <= 1'b1;
            end
          end
          default: err_pulse <= 1'b1;
        endcase
      end
    end
  end

  // Read response: BRAM data is valid during RD_WAIT and is captured into
  // rsp_data, which then holds until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= (state_q == ST_RD_WAIT);
      if (state_q == ST_RD_WAIT) begin
        rsp_data <= rd_err_q ? 8'h00 : fmap_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dpu_pio_responder.sv
// Scoreboard bench for dpu_pio_responder: stimulus pushes the expected output
// events, a monitor pops and compares whenever the DUT shows any strobe.
module tb_dpu_pio_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_type = '0;
  logic [23:0] cmd_addr = '0;
  logic [7:0]  cmd_data = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        core_busy = 1'b0;
  logic        core_reload_req = 1'b0;
  logic        wbuf_we;
  logic [17:0] wbuf_addr;
  logic [7:0]  wbuf_wdata;
  logic        bias_we;
  logic [9:0]  bias_addr;
  logic [7:0]  bias_wdata;
  logic        fmap_we;
  logic [15:0] fmap_waddr;
  logic [7:0]  fmap_wdata;
  logic        fmap_re;
  logic [15:0] fmap_raddr;
  logic [7:0]  fmap_rdata = '0;
  logic [4:0]  layer_sel;
  logic        run_pulse;
  logic        run_all_pulse;
  logic [15:0] scale_out;
  logic        desc_we;
  logic [4:0]  desc_layer;
  logic [3:0]  desc_field;
  logic [7:0]  desc_wdata;
  logic        err_pulse;

  dpu_pio_responder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_type        (cmd_type),
    .cmd_addr        (cmd_addr),
    .cmd_data        (cmd_data),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .core_busy       (core_busy),
    .core_reload_req (core_reload_req),
    .wbuf_we         (wbuf_we),
    .wbuf_addr       (wbuf_addr),
    .wbuf_wdata      (wbuf_wdata),
    .bias_we         (bias_we),
    .bias_addr       (bias_addr),
    .bias_wdata      (bias_wdata),
    .fmap_we         (fmap_we),
    .fmap_waddr      (fmap_waddr),
    .fmap_wdata      (fmap_wdata),
    .fmap_re         (fmap_re),
    .fmap_raddr      (fmap_raddr),
    .fmap_rdata      (fmap_rdata),
    .layer_sel       (layer_sel),
    .run_pulse       (run_pulse),
    .run_all_pulse   (run_all_pulse),
    .scale_out       (scale_out),
    .desc_we         (desc_we),
    .desc_layer      (desc_layer),
    .desc_field      (desc_field),
    .desc_wdata      (desc_wdata),
    .err_pulse       (err_pulse)
  );

  always #5 clk = ~clk;

  // Sync BRAM model: the stored byte is address[7:0] ^ 0x3B (addr 7 -> 0x3C).
  always @(posedge clk) begin
    if (fmap_re) fmap_rdata <= fmap_raddr[7:0] ^ 8'h3B;
  end

  // Strobe masks in the order of the monitored strobe vector.
  localparam logic [9:0] S_RDY  = 10'h200;
  localparam logic [9:0] S_WB   = 10'h100;
  localparam logic [9:0] S_BI   = 10'h080;
  localparam logic [9:0] S_FW   = 10'h040;
  localparam logic [9:0] S_FR   = 10'h020;
  localparam logic [9:0] S_RUN  = 10'h010;
  localparam logic [9:0] S_RALL = 10'h008;
  localparam logic [9:0] S_DESC = 10'h004;
  localparam logic [9:0] S_ERR  = 10'h002;
  localparam logic [9:0] S_RSP  = 10'h001;

  typedef struct {
    logic [9:0]  stb;
    logic [23:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  logic [9:0] strobes;
  assign strobes = {cmd_ready, wbuf_we, bias_we, fmap_we, fmap_re, run_pulse,
                    run_all_pulse, desc_we, err_pulse, rsp_valid};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [9:0] stb, input logic [23:0] addr, input logic [7:0] data);
    exp_t e;
    e.stb  = stb;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for the accept pulse, then drop valid after that edge.
  task automatic wait_ready();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (cmd_ready) seen = 1'b1;
    end
    if (!seen) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] t, input logic [23:0] a, input logic [7:0] d);
    cmd_type  = t;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    wait_ready();
  endtask

  // Monitor: every cycle with any strobe high must match the next expectation.
  int cyc = 0;
  int last_ready_cyc = -100;
  initial begin
    exp_t        e;
    logic [23:0] obs_addr;
    logic [7:0]  obs_data;
    forever begin
      @(negedge clk);
      if (strobes != 10'h000) begin
        obs_addr = '0;
        obs_data = '0;
        if (wbuf_we) begin
          obs_addr = {6'd0, wbuf_addr};   obs_data = wbuf_wdata;
        end else if (bias_we) begin
          obs_addr = {14'd0, bias_addr};  obs_data = bias_wdata;
        end else if (fmap_we) begin
          obs_addr = {8'd0, fmap_waddr};  obs_data = fmap_wdata;
        end else if (fmap_re) begin
          obs_addr = {8'd0, fmap_raddr};
        end else if (desc_we) begin
          obs_addr = {15'd0, desc_layer, desc_field}; obs_data = desc_wdata;
        end else if (rsp_valid) begin
          obs_data = rsp_data;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_strobes", {22'd0, strobes}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("strobes", {22'd0, strobes}, {22'd0, e.stb});
          check("addr", {8'd0, obs_addr}, {8'd0, e.addr});
          check("data", {24'd0, obs_data}, {24'd0, e.data});
        end
        if (cmd_ready) last_ready_cyc = cyc;
        if (rsp_valid) check("rsp_latency", cyc - last_ready_cyc, 32'd2);
      end
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_strobes", {22'd0, strobes}, 32'd0);
    check("reset_scale", {16'd0, scale_out}, 32'd0);
    check("reset_layer", {27'd0, layer_sel}, 32'd0);
    check("reset_rsp_data", {24'd0, rsp_data}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Writes across the three regions and their edges
    push(S_RDY | S_WB, 24'd5, 8'hA5);          send(3'd0, 24'd5, 8'hA5);
    push(S_RDY | S_FW, 24'd3, 8'h7F);          send(3'd0, 24'd148483, 8'h7F);
    push(S_RDY | S_ERR, 24'd0, 8'h00);         send(3'd0, 24'd214016, 8'h11);
    push(S_RDY | S_BI, 24'd10, 8'h55);         send(3'd0, 24'd147466, 8'h55);
    push(S_RDY | S_WB, 24'd147455, 8'h01);     send(3'd0, 24'd147455, 8'h01);
    push(S_RDY | S_BI, 24'd1023, 8'h02);       send(3'd0, 24'd148479, 8'h02);
    push(S_RDY | S_FW, 24'd65535, 8'h03);      send(3'd0, 24'd214015, 8'h03);
    push(S_RDY | S_WB, 24'd0, 8'hC3);          send(3'd0, 24'd0, 8'hC3);
    push(S_RDY | S_BI, 24'd0, 8'h44);          send(3'd0, 24'd147456, 8'h44);
    push(S_RDY | S_FW, 24'd0, 8'h66);          send(3'd0, 24'd148480, 8'h66);

    // Reads: out of range first (0x00 response), then a real one
    push(S_RDY | S_ERR, 24'd0, 8'h00);
    push(S_RSP, 24'd0, 8'h00);
    send(3'd2, 24'd65536, 8'h00);
    push(S_RDY | S_FR, 24'd7, 8'h00);
    push(S_RSP, 24'd0, 8'h3C);
    send(3'd2, 24'd7, 8'h00);
    push(S_RDY | S_FR, 24'd65535, 8'h00);
    push(S_RSP, 24'd0, 8'hC4);
    send(3'd2, 24'd65535, 8'h00);

    // Scale bytes
    push(S_RDY, 24'd0, 8'h00);                 send(3'd5, 24'd0, 8'h34);
    push(S_RDY, 24'd0, 8'h00);                 send(3'd5, 24'd1, 8'h12);
    check("scale_1234", {16'd0, scale_out}, 32'h1234);
    push(S_RDY, 24'd0, 8'h00);                 send(3'd5, 24'd0, 8'h56);
    check("scale_low_only", {16'd0, scale_out}, 32'h1256);

    // Layer select uses cmd_data[4:0]
    push(S_RDY, 24'd0, 8'h00);                 send(3'd3, 24'd0, 8'hE9);
    check("layer_sel", {27'd0, layer_sel}, 32'd9);

    // Descriptors: last valid layer, then first invalid one
    push(S_RDY | S_DESC, 24'd286, 8'h9A);      send(3'd6, 24'd286, 8'h9A);
    push(S_RDY | S_ERR, 24'd0, 8'h00);         send(3'd6, 24'd288, 8'h9B);

    // Reserved opcode
    push(S_RDY | S_ERR, 24'd0, 8'h00);         send(3'd7, 24'd0, 8'h00);

    // Accept gate: stalled while busy, accepted once reload is requested
    push(S_RDY | S_RALL, 24'd0, 8'h00);
    core_busy = 1'b1;
    cmd_type  = 3'd4;
    cmd_addr  = '0;
    cmd_data  = '0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_ready", {31'd0, cmd_ready}, 32'd0);
    end
    core_reload_req = 1'b1;
    wait_ready();
    push(S_RDY | S_RUN, 24'd0, 8'h00);         send(3'd1, 24'd0, 8'h00);
    core_busy       = 1'b0;
    core_reload_req = 1'b0;

    // Reset while a read waits for BRAM data: response must be discarded
    push(S_RDY | S_FR, 24'd20, 8'h00);
    send(3'd2, 24'd20, 8'h00);
    rst_n = 1'b0;
    #1;
    check("rst_rd_strobes", {22'd0, strobes}, 32'd0);
    check("rst_rd_scale", {16'd0, scale_out}, 32'd0);
    check("rst_rd_layer", {27'd0, layer_sel}, 32'd0);
    check("rst_rd_rsp_data", {24'd0, rsp_data}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    push(S_RDY | S_WB, 24'd9, 8'h66);          send(3'd0, 24'd9, 8'h66);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
